pe_div_unit: RTL and testbench
==============================

PE_DIV_UNIT -- requirements
Module: pe_div_unit

Interface
REQ-001 The block SHALL have parameter N_BITS, default 32: operand and result width.
REQ-002 The block SHALL have parameter BITS_PER_CYCLE, default 4 (radix 16): quotient bits resolved per cycle; N_BITS SHALL be a multiple of it.
REQ-003 The block SHALL derive localparam N_STAGES = N_BITS/BITS_PER_CYCLE, which is 8 at the defaults.
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single clock.
REQ-005 The block SHALL have port rst_n_i, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port in_valid_i, input, 1 bit: the operation request is valid.
REQ-007 The block SHALL have port in_ready_o, output, 1 bit: the unit can accept a request.
REQ-008 The block SHALL have port op_i, input, div_op_t (2 bits): DIV, DIVU, REM or REMU.
REQ-009 The block SHALL have port a_i, input, N_BITS: the dividend.
REQ-010 The block SHALL have port b_i, input, N_BITS: the divisor.
REQ-011 The block SHALL have port flush_i, input, 1 bit: synchronous abort.
REQ-012 The block SHALL have port out_valid_o, output, 1 bit: res_o is valid.
REQ-013 The block SHALL have port out_ready_i, input, 1 bit: the consumer accepts the result.
REQ-014 The block SHALL have port res_o, output, N_BITS: the quotient or the remainder.
REQ-015 The block SHALL have port busy_o, output, 1 bit: the FSM is not in IDLE.

Function
REQ-016 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-017 in_ready_o SHALL equal (state==IDLE) & ~flush_i.
REQ-018 Acceptance SHALL be defined as in_valid_i & in_ready_o on a clock edge.
REQ-019 On acceptance the block SHALL latch op, a and b, and move to CALC with the stage counter at 0.
REQ-020 If b==0 at acceptance, the block SHALL go straight to DONE: DIV/DIVU give all-ones, REM/REMU give a.
REQ-021 If op is DIV or REM, a is the most negative value and b is all-ones, the block SHALL go straight to DONE: DIV gives a, REM gives 0.
REQ-022 For signed ops, the block SHALL divide magnitudes.
REQ-023 The final quotient SHALL be negated when the operand signs differ.
REQ-024 The final remainder SHALL take the sign of the dividend.
REQ-025 In CALC, each cycle SHALL resolve BITS_PER_CYCLE quotient bits by restoring division, MSB first.
REQ-026 The block SHALL go to DONE after N_STAGES CALC cycles, registering the sign-corrected result.
REQ-027 Normal latency SHALL be as follows: acceptance edge is cycle 0, and out_valid_o rises at cycle N_STAGES+1 (9 at the defaults).
REQ-028 Special-case latency (REQ-020, REQ-021) SHALL be 1 cycle.
REQ-029 In DONE, out_valid_o SHALL be 1, and res_o SHALL be held stable until out_valid_o & out_ready_i.
REQ-030 On that output handshake the FSM SHALL return to IDLE; a new request SHALL be accepted no earlier than the next cycle.
REQ-031 flush_i=1 SHALL force IDLE on the next edge from any state.
REQ-032 A flush SHALL discard any result without an output handshake.
REQ-033 A flush SHALL win over a simultaneous in_valid_i or out_ready_i.
REQ-034 out_valid_o SHALL be 0 in IDLE and in CALC.
REQ-035 res_o SHALL be driven only from registers; there SHALL be no combinational path from inputs to outputs except in_ready_o from flush_i.

Reset
REQ-036 While rst_n_i is low, the FSM SHALL be in IDLE and the stage counter SHALL be 0.
REQ-037 While rst_n_i is low, res_o, out_valid_o and busy_o SHALL be 0, and in_ready_o SHALL be 1 (when flush_i=0).
REQ-038 Reset asserted mid-operation SHALL abort immediately and asynchronously, with no output handshake.

Structure
REQ-039 div_op_t (DIV=2'b00, DIVU=2'b01, REM=2'b10, REMU=2'b11) SHALL live in pea_pkg.
REQ-040 Default constants SHALL live in pea_pkg, with N_RADIX and N_DIV_STAGE kept consistent with BITS_PER_CYCLE and N_STAGES.
REQ-041 One combinational sub-module, pe_div_step, SHALL perform BITS_PER_CYCLE restoring iterations.
REQ-042 pe_div_step SHALL map remainder, quotient and divisor in to remainder and quotient out.

Verification
REQ-043 DIVU 100/7 accepted at cycle 0, with out_ready_i=1, SHALL give res_o=14 at cycle 9; REMU SHALL give 2.
REQ-044 DIV -20/3 SHALL give 0xFFFFFFFA (-6); REM -20/3 SHALL give 0xFFFFFFFE (-2); REM 20/-3 SHALL give 2.
REQ-045 DIVU 5/0 SHALL give 0xFFFFFFFF and REMU 5/0 SHALL give 5, both with out_valid_o at cycle 1.
REQ-046 DIV 0x80000000/0xFFFFFFFF SHALL give 0x80000000, and REM of the same operands SHALL give 0, both at cycle 1.
REQ-047 With out_ready_i held low for 5 cycles in DONE, res_o and out_valid_o SHALL stay stable and in_ready_o SHALL stay 0; the handshake SHALL then return the FSM to IDLE.
REQ-048 flush_i at cycle 4 of CALC, and separately rst_n_i low at cycle 4, SHALL give IDLE next, with no out_valid_o; a following request SHALL then complete correctly.

Source files
------------

// File: rtl/pea_pkg.sv
// Shared types and default constants for the radix-16 processing-element divider.
package pea_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } div_state_e;

  localparam int unsigned N_BITS_DEF         = 32;
  localparam int unsigned BITS_PER_CYCLE_DEF = 4;
  localparam int unsigned N_RADIX            = 1 << BITS_PER_CYCLE_DEF;
  localparam int unsigned N_DIV_STAGE        = N_BITS_DEF / BITS_PER_CYCLE_DEF;

endpackage

// File: rtl/pe_div_step.sv
// Combinational block of BITS_PER_CYCLE restoring-division iterations, MSB first.
module pe_div_step
  import pea_pkg::*;
#(
  parameter int unsigned N_BITS         = N_BITS_DEF,
  parameter int unsigned BITS_PER_CYCLE = BITS_PER_CYCLE_DEF
) (
  input  logic [N_BITS-1:0] rem_i,
  input  logic [N_BITS-1:0] quo_i,
  input  logic [N_BITS-1:0] div_i,
  output logic [N_BITS-1:0] rem_o,
  output logic [N_BITS-1:0] quo_o
);

  logic [N_BITS:0]   rem_w;
  logic [N_BITS-1:0] quo_w;

  // quo holds the unconsumed dividend bits on top and the new quotient bits below.
  always_comb begin
    rem_w = {1'b0, rem_i};
    quo_w = quo_i;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      rem_w = {rem_w[N_BITS-1:0], quo_w[N_BITS-1]};
      quo_w = {quo_w[N_BITS-2:0], 1'b0};
      if (rem_w >= {1'b0, div_i}) begin
        rem_w    = rem_w - {1'b0, div_i};
        quo_w[0] = 1'b1;
      end
    end
    rem_o = rem_w[N_BITS-1:0];
    quo_o = quo_w;
  end

endmodule

// File: rtl/pe_div_unit.sv
// Iterative signed/unsigned divider: magnitudes are divided BITS_PER_CYCLE bits per cycle,
// signs are applied when the result is registered.
module pe_div_unit
  import pea_pkg::*;
#(
  parameter int unsigned N_BITS         = N_BITS_DEF,
  parameter int unsigned BITS_PER_CYCLE = BITS_PER_CYCLE_DEF
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  div_op_t           op_i,
  input  logic [N_BITS-1:0] a_i,
  input  logic [N_BITS-1:0] b_i,
  input  logic              flush_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [N_BITS-1:0] res_o,
  output logic              busy_o
);

  localparam int unsigned N_STAGES = N_BITS / BITS_PER_CYCLE;
  localparam int unsigned CntW     = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
  localparam logic [CntW-1:0]   LastStage = CntW'(N_STAGES - 1);
  localparam logic [N_BITS-1:0] MinNeg    = {1'b1, {(N_BITS-1){1'b0}}};

  div_state_e        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [N_BITS-1:0] rem_q, rem_d;
  logic [N_BITS-1:0] quo_q, quo_d;
  logic [N_BITS-1:0] div_q, div_d;
  logic [N_BITS-1:0] res_q, res_d;
  logic              is_rem_q, is_rem_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;

  logic              signed_op, is_rem_op, a_neg, b_neg, div_by_zero, overflow;
  logic [N_BITS-1:0] a_mag, b_mag;
  logic [N_BITS-1:0] step_rem, step_quo, quo_fin, rem_fin;

  assign signed_op   = (op_i == DIV) || (op_i == REM);
  assign is_rem_op   = (op_i == REM) || (op_i == REMU);
  assign a_neg       = signed_op & a_i[N_BITS-1];
  assign b_neg       = signed_op & b_i[N_BITS-1];
  assign a_mag       = a_neg ? -a_i : a_i;
  assign b_mag       = b_neg ? -b_i : b_i;
  assign div_by_zero = (b_i == '0);
  assign overflow    = signed_op && (a_i == MinNeg) && (b_i == '1);

  pe_div_step #(
    .N_BITS         (N_BITS),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .div_i (div_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  assign quo_fin = neg_quo_q ? -step_quo : step_quo;
  assign rem_fin = neg_rem_q ? -step_rem : step_rem;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    div_d     = div_q;
    res_d     = res_q;
    is_rem_d  = is_rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    if (flush_i) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid_i) begin
            cnt_d     = '0;
            rem_d     = '0;
            quo_d     = a_mag;
            div_d     = b_mag;
            is_rem_d  = is_rem_op;
            neg_quo_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            if (div_by_zero) begin
              state_d = StDone;
              res_d   = is_rem_op ? a_i : '1;
            end else if (overflow) begin
              state_d = StDone;
              res_d   = is_rem_op ? '0 : a_i;
            end else begin
              state_d = StCalc;
            end
          end
        end
        StCalc: begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastStage) begin
            state_d = StDone;
            cnt_d   = '0;
            res_d   = is_rem_q ? rem_fin : quo_fin;
          end
        end
        StDone: begin
          if (out_ready_i) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      div_q     <= '0;
      res_q     <= '0;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      div_q     <= div_d;
      res_q     <= res_d;
      is_rem_q  <= is_rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  assign in_ready_o  = (state_q == StIdle) & ~flush_i;
  assign out_valid_o = (state_q == StDone);
  assign busy_o      = (state_q != StIdle);
  assign res_o       = res_q;

endmodule

// File: tb/tb_pe_div_unit.sv
// Scoreboard bench for pe_div_unit: latency is counted in edges from the acceptance edge (0).
module tb_pe_div_unit;
  import pea_pkg::*;

  typedef struct {
    div_op_t     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  div_op_t     op = DIVU;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] res_o;
  logic        busy;

  int          n_cmp = 0;
  int          n_mis = 0;
  logic [31:0] exp_q[$];
  int          lat_q[$];

  pe_div_unit #(
    .N_BITS         (32),
    .BITS_PER_CYCLE (4)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .op_i        (op),
    .a_i         (a),
    .b_i         (b),
    .flush_i     (flush),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .res_o       (res_o),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [31:0] model(input div_op_t o, input logic [31:0] x,
                                        input logic [31:0] y);
    logic [31:0] r;
    if (y == 32'd0) r = (o == DIV || o == DIVU) ? 32'hFFFF_FFFF : x;
    else if ((o == DIV || o == REM) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
      r = (o == DIV) ? x : 32'd0;
    else begin
      case (o)
        DIV:     r = $signed(x) / $signed(y);
        DIVU:    r = x / y;
        REM:     r = $signed(x) % $signed(y);
        default: r = x % y;
      endcase
    end
    return r;
  endfunction

  function automatic int model_lat(input div_op_t o, input logic [31:0] x, input logic [31:0] y);
    if (y == 32'd0) return 1;
    if ((o == DIV || o == REM) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
    return 9;
  endfunction

  // Drives one request so that the next posedge is the acceptance edge.
  task automatic issue(input div_op_t o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] er, input int el, input bit push);
    @(negedge clk);
    in_valid = 1'b1;
    op = o;
    a = x;
    b = y;
    if (push) begin
      exp_q.push_back(er);
      lat_q.push_back(el);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Waits for out_valid (sampled before each edge); handshake consumes it on the next edge.
  task automatic collect(output logic [31:0] r, output int lat);
    lat = 1;
    r = 'x;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        r = res_o;
        @(posedge clk);
        #1;
        return;
      end
      lat++;
    end
    lat = -1;
  endtask

  task automatic test_reset();
    in_valid = 1'b1;
    op = DIVU; a = 32'd9; b = 32'd3;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || res_o !== 32'd0 || in_ready !== 1'b1) begin
      n_mis++;
      $display("FAIL reset: busy=%b out_valid=%b res=%h in_ready=%b, want 0 0 0 1",
               busy, out_valid, res_o, in_ready);
    end
    flush = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_mis++;
      $display("FAIL reset_flush_ready: in_ready=%b want 0", in_ready);
    end
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_unsigned();
    vec_t v[$];
    logic [31:0] r, e;
    int l, el;
    v.push_back('{DIVU, 32'd100, 32'd7, 32'd14, 9});
    v.push_back('{REMU, 32'd100, 32'd7, 32'd2, 9});
    v.push_back('{DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 9});
    v.push_back('{REMU, 32'hFFFF_FFFF, 32'h10, 32'hF, 9});
    v.push_back('{DIVU, 32'd3, 32'd5, 32'd0, 9});
    v.push_back('{DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 9});
    foreach (v[i]) begin
      issue(v[i].op, v[i].a, v[i].b, v[i].res, v[i].lat, 1'b1);
      collect(r, l);
      e = exp_q.pop_front();
      el = lat_q.pop_front();
      n_cmp++;
      if (r !== e || l != el) begin
        n_mis++;
        $display("FAIL unsigned[%0d]: res=%h lat=%0d, want res=%h lat=%0d", i, r, l, e, el);
      end
    end
  endtask

  task automatic test_signed();
    vec_t v[$];
    logic [31:0] r, e;
    int l, el;
    v.push_back('{DIV, -32'sd20, 32'd3, 32'hFFFF_FFFA, 9});
    v.push_back('{REM, -32'sd20, 32'd3, 32'hFFFF_FFFE, 9});
    v.push_back('{REM, 32'd20, -32'sd3, 32'd2, 9});
    v.push_back('{DIV, 32'd20, -32'sd3, 32'hFFFF_FFFA, 9});
    v.push_back('{DIV, -32'sd7, -32'sd2, 32'd3, 9});
    v.push_back('{REM, -32'sd7, -32'sd2, 32'hFFFF_FFFF, 9});
    v.push_back('{DIV, 32'h8000_0000, 32'd1, 32'h8000_0000, 9});
    foreach (v[i]) begin
      issue(v[i].op, v[i].a, v[i].b, v[i].res, v[i].lat, 1'b1);
      collect(r, l);
      e = exp_q.pop_front();
      el = lat_q.pop_front();
      n_cmp++;
      if (r !== e || l != el) begin
        n_mis++;
        $display("FAIL signed[%0d]: res=%h lat=%0d, want res=%h lat=%0d", i, r, l, e, el);
      end
    end
  endtask

  task automatic test_special();
    vec_t v[$];
    logic [31:0] r, e;
    int l, el;
    v.push_back('{DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1});
    v.push_back('{REMU, 32'd5, 32'd0, 32'd5, 1});
    v.push_back('{DIV, -32'sd9, 32'd0, 32'hFFFF_FFFF, 1});
    v.push_back('{REM, -32'sd9, 32'd0, 32'hFFFF_FFF7, 1});
    v.push_back('{DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1});
    v.push_back('{REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1});
    foreach (v[i]) begin
      issue(v[i].op, v[i].a, v[i].b, v[i].res, v[i].lat, 1'b1);
      collect(r, l);
      e = exp_q.pop_front();
      el = lat_q.pop_front();
      n_cmp++;
      if (r !== e || l != el) begin
        n_mis++;
        $display("FAIL special[%0d]: res=%h lat=%0d, want res=%h lat=%0d", i, r, l, e, el);
      end
    end
  endtask

  task automatic test_backpressure();
    int l;
    out_ready = 1'b0;
    issue(DIVU, 32'd1000, 32'd10, 32'd100, 9, 1'b0);
    l = 1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) break;
      l++;
    end
    n_cmp++;
    if (l != 9) begin
      n_mis++;
      $display("FAIL stall_latency: lat=%0d want 9", l);
    end
    // A competing request during the stall must not be taken.
    in_valid = 1'b1;
    op = DIVU; a = 32'd77; b = 32'd7;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || res_o !== 32'd100 || in_ready !== 1'b0) begin
        n_mis++;
        $display("FAIL stall_hold[%0d]: out_valid=%b res=%h in_ready=%b, want 1 00000064 0",
                 k, out_valid, res_o, in_ready);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_mis++;
      $display("FAIL stall_release: busy=%b in_ready=%b out_valid=%b, want 0 1 0",
               busy, in_ready, out_valid);
    end
  endtask

  task automatic test_flush();
    logic [31:0] r, e;
    int l, el;
    bit seen;
    issue(DIVU, 32'd1000, 32'd7, 32'd0, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    flush = 1'b1;
    in_valid = 1'b1;
    op = DIVU; a = 32'd50; b = 32'd5;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_mis++;
      $display("FAIL flush_ready: in_ready=%b want 0", in_ready);
    end
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_mis++;
      $display("FAIL flush_idle: busy=%b out_valid=%b want 0 0", busy, out_valid);
    end
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin
      n_mis++;
      $display("FAIL flush_discard: activity=%b after flush, want 0", seen);
    end
    issue(REMU, 32'd1000, 32'd7, 32'd6, 9, 1'b1);
    collect(r, l);
    e = exp_q.pop_front();
    el = lat_q.pop_front();
    n_cmp++;
    if (r !== e || l != el) begin
      n_mis++;
      $display("FAIL flush_after: res=%h lat=%0d, want res=%h lat=%0d", r, l, e, el);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] r, e;
    int l, el;
    issue(DIV, -32'sd1000, 32'd7, 32'd0, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || res_o !== 32'd0) begin
      n_mis++;
      $display("FAIL reset_abort: busy=%b out_valid=%b res=%h, want 0 0 0",
               busy, out_valid, res_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    issue(DIV, -32'sd1000, 32'd7, 32'hFFFF_FF72, 9, 1'b1);
    collect(r, l);
    e = exp_q.pop_front();
    el = lat_q.pop_front();
    n_cmp++;
    if (r !== e || l != el) begin
      n_mis++;
      $display("FAIL reset_after: res=%h lat=%0d, want res=%h lat=%0d", r, l, e, el);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r, e, x, y;
    int l, el;
    div_op_t o;
    for (int i = 0; i < 24; i++) begin
      o = div_op_t'($urandom_range(0, 3));
      x = $urandom;
      y = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : 32'($urandom);
      if (i == 5) begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
      issue(o, x, y, model(o, x, y), model_lat(o, x, y), 1'b1);
      collect(r, l);
      e = exp_q.pop_front();
      el = lat_q.pop_front();
      n_cmp++;
      if (r !== e || l != el) begin
        n_mis++;
        $display("FAIL b2b[%0d] op=%s a=%h b=%h: res=%h lat=%0d, want res=%h lat=%0d",
                 i, o.name(), x, y, r, l, e, el);
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_mis++;
      $display("FAIL scoreboard_drain: %0d left, want 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_special();
    test_backpressure();
    test_flush();
    test_reset_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
